// File: rtl/alarm_ctrl.sv
// Alarm controller: stores an alarm time and rings, auto-stops or snoozes on 1 Hz ticks.
// Optional snooze path is enabled by defining ALARM_SNOOZE_EN.
module alarm_ctrl #(
  parameter int unsigned RING_SECONDS   = 60,
  parameter int unsigned SNOOZE_SECONDS = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hh,
  input  logic [5:0] cur_mm,
  input  logic [5:0] cur_ss,
  input  logic       set_en,
  input  logic [4:0] set_hh,
  input  logic [5:0] set_mm,
  input  logic       arm,
  input  logic       ack,
  input  logic       snooze,
  output logic       flag,
  output logic       ringing,
  output logic       snoozing,
  output logic [4:0] alm_hh,
  output logic [5:0] alm_mm
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  localparam logic [15:0] RING_LOAD   = 16'(RING_SECONDS - 1);
  localparam logic [15:0] SNOOZE_LOAD = 16'(SNOOZE_SECONDS - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        set_ok;
  logic        match;
  logic        snooze_req;

  assign set_ok = (set_hh <= 5'd23) && (set_mm <= 6'd59);
  assign match  = tick_1hz && (cur_hh == alm_hh) && (cur_mm == alm_mm) && (cur_ss == 6'd0);

`ifdef ALARM_SNOOZE_EN
  assign snooze_req = snooze;
`else
  // Snooze input is consumed but masked so SNOOZE can never be entered.
  assign snooze_req = snooze & 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      flag     <= 1'b0;
      ringing  <= 1'b0;
      snoozing <= 1'b0;
      alm_hh   <= '0;
      alm_mm   <= '0;
    end else begin
      if (set_en && set_ok) begin
        alm_hh <= set_hh;
        alm_mm <= set_mm;
      end

      if (!arm) begin
        state    <= IDLE;
        flag     <= 1'b0;
        ringing  <= 1'b0;
        snoozing <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= ARMED;
          end
          ARMED: begin
            // A load strobe outranks the tick, so it suppresses a coincident match.
            if (!set_en && match) begin
              state   <= RINGING;
              cnt     <= RING_LOAD;
              flag    <= 1'b1;
              ringing <= 1'b1;
            end
          end
          RINGING: begin
            if (set_en || ack) begin
              state   <= ARMED;
              flag    <= 1'b0;
              ringing <= 1'b0;
            end else if (snooze_req) begin
              state    <= SNOOZE;
              cnt      <= SNOOZE_LOAD;
              flag     <= 1'b0;
              ringing  <= 1'b0;
              snoozing <= 1'b1;
            end else if (tick_1hz) begin
              if (cnt == 16'd0) begin
                state   <= ARMED;
                flag    <= 1'b0;
                ringing <= 1'b0;
              end else begin
                cnt <= cnt - 16'd1;
              end
            end
          end
          SNOOZE: begin
            if (set_en || ack) begin
              state    <= ARMED;
              snoozing <= 1'b0;
            end else if (tick_1hz) begin
              if (cnt == 16'd0) begin
                state    <= RINGING;
                cnt      <= RING_LOAD;
                flag     <= 1'b1;
                ringing  <= 1'b1;
                snoozing <= 1'b0;
              end else begin
                cnt <= cnt - 16'd1;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
